// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a combinational instruction memory and
// registers the returned word with its PC into a valid/ready IF/ID register.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PC_STEP  = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_word,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_target,
    input  logic              i_halt_req,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_pc,
    output logic [31:0]       o_out_instr,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] L_STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  L_CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic [ADDR_W-1:0]  r_out_pc;
    logic [ADDR_W-1:0]  w_out_pc_nxt;
    logic [31:0]        r_out_instr;
    logic [31:0]        w_out_instr_nxt;
    logic               r_halted;
    logic [CNT_W-1:0]   r_fetch_count;
    logic               w_can_load;
    logic               w_accept;

    assign w_can_load = !r_out_valid || i_out_ready;
    assign w_accept   = r_out_valid && i_out_ready;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: halt_req alone decides between RUN and HALT once out of BOOT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = i_halt_req ? S_HALT : S_RUN;
            S_RUN:   w_state_nxt = i_halt_req ? S_HALT : S_RUN;
            S_HALT:  w_state_nxt = i_halt_req ? S_HALT : S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // PC and IF/ID next values; redirect flushes and wins over fetch, stall and halt
    always_comb begin
        w_pc_nxt        = r_pc;
        w_out_valid_nxt = r_out_valid;
        w_out_pc_nxt    = r_out_pc;
        w_out_instr_nxt = r_out_instr;
        if (i_redirect_valid) begin
            w_pc_nxt        = i_redirect_target;
            w_out_valid_nxt = 1'b0;
        end else if (r_state == S_RUN && w_can_load) begin
            w_pc_nxt        = r_pc + L_STEP;
            w_out_valid_nxt = 1'b1;
            w_out_pc_nxt    = r_pc;
            w_out_instr_nxt = i_imem_word;
        end else if (r_state != S_RUN && w_accept) begin
            w_out_valid_nxt = 1'b0;
        end else begin
            w_out_valid_nxt = r_out_valid;
        end
    end

    // Datapath, status and accepted-instruction counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= L_RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_pc      <= {ADDR_W{1'b0}};
            r_out_instr   <= 32'h0000_0000;
            r_halted      <= 1'b0;
            r_fetch_count <= {CNT_W{1'b0}};
        end else begin
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_pc    <= w_out_pc_nxt;
            r_out_instr <= w_out_instr_nxt;
            r_halted    <= (w_state_nxt == S_HALT);
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + L_CNT_ONE;
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_out_valid   = r_out_valid;
    assign o_out_pc      = r_out_pc;
    assign o_out_instr   = r_out_instr;
    assign o_halted      = r_halted;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: each scenario task drives inputs and checks
// {out_valid, out_pc, imem_addr, halted, fetch_count} plus out_instr against hand values.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_word;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    wire [33:0] obs = {out_valid, out_pc, imem_addr, halted, fetch_count};

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hC0, a, ~a, a ^ 8'h5A};
    endfunction

    assign imem_word = mem_word(imem_addr);

    fetch_unit dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .o_imem_addr       (imem_addr),
        .i_imem_word       (imem_word),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_halt_req        (halt_req),
        .o_out_valid       (out_valid),
        .i_out_ready       (out_ready),
        .o_out_pc          (out_pc),
        .o_out_instr       (out_instr),
        .o_halted          (halted),
        .o_fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [33:0] exp;
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 8'h00; halt_req = 1'b0;
        step(); step();
        exp = {1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
        checks++;
        if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", out_instr, 32'h0); end
    endtask

    task automatic test_fetch_seq();
        logic [33:0] exp;
        rst = 1'b0;
        step();
        exp = {1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL boot_bubble got=%h exp=%h", obs, exp); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] pc;
            pc = 8'(i * 16);
            step();
            exp = {1'b1, pc, pc + 8'h10, 1'b0, 16'(i)};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL seq_%0d got=%h exp=%h", i, obs, exp); end
            checks++;
            if (out_instr !== mem_word(pc)) begin errors++; $display("FAIL seq_instr_%0d got=%h exp=%h", i, out_instr, mem_word(pc)); end
        end
    endtask

    task automatic test_stall();
        logic [33:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = {1'b1, 8'h30, 8'h40, 1'b0, 16'd3};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL stall_%0d got=%h exp=%h", i, obs, exp); end
            checks++;
            if (out_instr !== mem_word(8'h30)) begin errors++; $display("FAIL stall_instr_%0d got=%h exp=%h", i, out_instr, mem_word(8'h30)); end
        end
        out_ready = 1'b1;
        step();
        exp = {1'b1, 8'h40, 8'h50, 1'b0, 16'd4};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_release got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 8'h50, 8'h60, 1'b0, 16'd5};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_resume got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_redirect();
        logic [33:0] exp;
        out_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_target = 8'hA4;
        step();
        exp = {1'b0, 8'h50, 8'hA4, 1'b0, 16'd5};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_flush got=%h exp=%h", obs, exp); end
        redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        exp = {1'b1, 8'hA4, 8'hB4, 1'b0, 16'd5};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_target got=%h exp=%h", obs, exp); end
        checks++;
        if (out_instr !== mem_word(8'hA4)) begin errors++; $display("FAIL redirect_instr got=%h exp=%h", out_instr, mem_word(8'hA4)); end
        step();
        exp = {1'b1, 8'hB4, 8'hC4, 1'b0, 16'd6};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_next got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_wrap();
        logic [33:0] exp;
        redirect_valid = 1'b1; redirect_target = 8'hF0;
        step();
        exp = {1'b0, 8'hB4, 8'hF0, 1'b0, 16'd7};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_accept_count got=%h exp=%h", obs, exp); end
        redirect_valid = 1'b0;
        step();
        exp = {1'b1, 8'hF0, 8'h00, 1'b0, 16'd7};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_f0 got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 8'h00, 8'h10, 1'b0, 16'd8};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_00 got=%h exp=%h", obs, exp); end
        checks++;
        if (out_instr !== mem_word(8'h00)) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", out_instr, mem_word(8'h00)); end
    endtask

    task automatic test_halt();
        logic [33:0] exp;
        halt_req = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) out_ready = 1'b1;
            step();
            if (i < 2) exp = {1'b1, 8'h00, 8'h10, 1'b1, 16'd8};
            else       exp = {1'b0, 8'h00, 8'h10, 1'b1, 16'd9};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL halt_%0d got=%h exp=%h", i, obs, exp); end
        end
        halt_req = 1'b0;
        step();
        exp = {1'b0, 8'h00, 8'h10, 1'b0, 16'd9};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL unhalt got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 8'h10, 8'h20, 1'b0, 16'd9};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL halt_resume got=%h exp=%h", obs, exp); end
        checks++;
        if (out_instr !== mem_word(8'h10)) begin errors++; $display("FAIL halt_resume_instr got=%h exp=%h", out_instr, mem_word(8'h10)); end
    endtask

    task automatic test_redirect_halt();
        logic [33:0] exp;
        redirect_valid = 1'b1; redirect_target = 8'h33; halt_req = 1'b1;
        step();
        exp = {1'b0, 8'h10, 8'h33, 1'b1, 16'd10};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_halt got=%h exp=%h", obs, exp); end
        redirect_valid = 1'b0; halt_req = 1'b0;
        step();
        exp = {1'b0, 8'h10, 8'h33, 1'b0, 16'd10};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_unhalt got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 8'h33, 8'h43, 1'b0, 16'd10};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL redirect_halt_fetch got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_reset_mid_stall();
        logic [33:0] exp;
        out_ready = 1'b0;
        step();
        exp = {1'b1, 8'h33, 8'h43, 1'b0, 16'd10};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL pre_reset_stall got=%h exp=%h", obs, exp); end
        rst = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h99;
        step();
        exp = {1'b0, 8'h00, 8'h00, 1'b0, 16'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_stall got=%h exp=%h", obs, exp); end
        checks++;
        if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_mid_stall_instr got=%h exp=%h", out_instr, 32'h0); end
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL post_reset_boot got=%h exp=%h", obs, exp); end
        step();
        exp = {1'b1, 8'h00, 8'h10, 1'b0, 16'd0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL post_reset_fetch got=%h exp=%h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_redirect_halt();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
